// File: rtl/shift_add_multiplier_4_pkg.sv
// rtl/shift_add_multiplier_4_pkg.sv - shared state encoding and default width for the shift-add multiplier
package shift_add_multiplier_4_pkg;

    // Default operand width; the product is twice this wide.
    localparam int MUL_WIDTH = 4;

    // Controller states. 2'b11 is unused and decodes back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_4_mul_step.sv
// rtl/shift_add_multiplier_4_mul_step.sv - one combinational shift-add step: conditional accumulate
// Ports:
//   acc      : running partial sum
//   mcand    : current (already shifted) multiplicand
//   mplier_lsb : multiplier bit selecting whether mcand is added this step
//   acc_next : partial sum after this step
module mul_step
    import shift_add_multiplier_4_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic               mplier_lsb,
    output logic [2*WIDTH-1:0] acc_next
);

    // A full product always fits in 2*WIDTH bits, so the sum never overflows.
    assign acc_next = mplier_lsb ? (acc + mcand) : acc;

endmodule

// File: rtl/shift_add_multiplier_4.sv
// rtl/shift_add_multiplier_4.sv - multi-cycle unsigned shift-and-add multiplier with start/busy/done
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   start : begin a multiply, sampled only while idle
//   in1   : multiplicand, latched on an accepted start
//   in2   : multiplier, latched on an accepted start
//   busy  : high while the WIDTH shift-add steps run
//   done  : one-cycle pulse when out1 has just been updated
//   out1  : registered product, held until the next completion
module shift_add_multiplier_4
    import shift_add_multiplier_4_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out1
);

    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_t            state;
    logic [2*WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]      mplier;
    logic [2*WIDTH-1:0]    acc;
    logic [CW-1:0]         cnt;
    logic [2*WIDTH-1:0]    acc_next;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier_lsb (mplier[0]),
        .acc_next   (acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            out1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, in1};
                        mplier <= in2;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // The last step's sum goes straight to out1 so partial
                    // sums are never visible on the output.
                    if (cnt == CW'(WIDTH - 1)) begin
                        out1  <= acc_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier_4.sv
// tb/tb_shift_add_multiplier_4.sv - self-checking bench for shift_add_multiplier_4
module tb_shift_add_multiplier_4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] in1 = 4'h0;
    logic [3:0] in2 = 4'h0;
    logic       busy;
    logic       done;
    logic [7:0] out1;

    int vectors = 0;
    int miscompares = 0;

    shift_add_multiplier_4 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out1  (out1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input int a, input int b);
        return 8'(a * b);
    endfunction

    // Issues one start pulse and follows the operation to its done pulse.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int nbusy, output logic [7:0] p,
                          output bit got_done, output bit glitch);
        logic [7:0] held;
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        held = out1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; got_done = 1'b0; glitch = 1'b0; p = 8'h00;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (busy) begin
                nbusy++;
                if (out1 !== held) glitch = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                p = out1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        int nb;
        bit gd;
        start = 1'b1; in1 = 4'h3; in2 = 4'h5; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out1 !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: out1=%h busy=%b done=%b required out1=00 busy=0 done=0", out1, busy, done);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_accept: busy=%b required 1", busy);
        end
        nb = 1; gd = 1'b0;
        for (int i = 0; i < 20 && !gd; i++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
        end
        vectors++;
        if (!gd || out1 !== ref_mul(3, 5)) begin
            miscompares++;
            $display("FAIL reset_first_result: done_seen=%b out1=%h required %h", gd, out1, ref_mul(3, 5));
        end
    endtask

    task automatic test_max();
        int nb; logic [7:0] p; bit gd, gl;
        run_op(4'hF, 4'hF, nb, p, gd, gl);
        vectors++;
        if (!gd || p !== 8'hE1) begin
            miscompares++;
            $display("FAIL max_product: done_seen=%b out1=%h required E1", gd, p);
        end
        vectors++;
        if (nb !== 4) begin
            miscompares++;
            $display("FAIL max_busy_cycles: got %0d required 4", nb);
        end
        vectors++;
        if (gl) begin
            miscompares++;
            $display("FAIL max_no_partial: out1 changed during busy, required stable");
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL max_done_width: done=%b busy=%b required 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (out1 !== 8'hE1) begin
            miscompares++;
            $display("FAIL max_hold: out1=%h required E1", out1);
        end
    endtask

    task automatic test_zero_identity();
        logic [3:0] ta [3] = '{4'h0, 4'h1, 4'hA};
        logic [3:0] tb [3] = '{4'h9, 4'hB, 4'h3};
        int nb; logic [7:0] p; bit gd, gl;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], nb, p, gd, gl);
            vectors++;
            if (!gd || p !== ref_mul(int'(ta[i]), int'(tb[i])) || nb !== 4) begin
                miscompares++;
                $display("FAIL zero_identity %h*%h: out1=%h busy_cycles=%0d required %h 4",
                         ta[i], tb[i], p, nb, ref_mul(int'(ta[i]), int'(tb[i])));
            end
        end
    endtask

    task automatic test_ignored_start();
        bit gd; int extra_done; int extra_busy;
        @(negedge clk);
        in1 = 4'h7; in2 = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in1 = 4'hF; in2 = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gd = 1'b0;
        for (int i = 0; i < 20 && !gd; i++) begin
            if (done) gd = 1'b1; else @(negedge clk);
        end
        vectors++;
        if (!gd || out1 !== 8'h23) begin
            miscompares++;
            $display("FAIL ignored_start_result: done_seen=%b out1=%h required 23", gd, out1);
        end
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        vectors++;
        if (extra_done != 0 || extra_busy != 0) begin
            miscompares++;
            $display("FAIL ignored_start_no_second: done_pulses=%0d busy_cycles=%0d required 0 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_reset_mid();
        int nb; logic [7:0] p; bit gd, gl;
        @(negedge clk);
        in1 = 4'hF; in2 = 4'hF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (out1 !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async: out1=%h busy=%b done=%b required 00 0 0", out1, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(4'h2, 4'h3, nb, p, gd, gl);
        vectors++;
        if (!gd || p !== 8'h06 || nb !== 4) begin
            miscompares++;
            $display("FAIL reset_mid_recover: out1=%h busy_cycles=%0d required 06 4", p, nb);
        end
    endtask

    task automatic test_random();
        int nb; logic [7:0] p; bit gd, gl;
        logic [3:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            run_op(a, b, nb, p, gd, gl);
            vectors++;
            if (!gd || p !== ref_mul(int'(a), int'(b)) || nb !== 4 || gl) begin
                miscompares++;
                $display("FAIL random %h*%h: out1=%h busy_cycles=%0d glitch=%b required %h 4 0",
                         a, b, p, nb, gl, ref_mul(int'(a), int'(b)));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expq[$];
        int accepted, results, last_done, cyc;
        bit prev_busy;
        int cur;
        @(negedge clk);
        cur = 0;
        in1 = 4'(cur / 16); in2 = 4'(cur % 16); start = 1'b1;
        accepted = 0; results = 0; last_done = -1; prev_busy = 1'b0;
        for (cyc = 0; cyc < 256 * 6 + 60 && results < 256; cyc++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                expq.push_back(ref_mul(cur / 16, cur % 16));
                accepted++;
                cur++;
                if (accepted >= 256) start = 1'b0;
                else begin
                    in1 = 4'(cur / 16); in2 = 4'(cur % 16);
                end
            end
            prev_busy = busy;
            if (done) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_unexpected_done: out1=%h required no done", out1);
                end else begin
                    logic [7:0] e;
                    e = expq.pop_front();
                    if (out1 !== e) begin
                        miscompares++;
                        $display("FAIL b2b_product #%0d: out1=%h required %h", results, out1, e);
                    end
                end
                if (last_done >= 0) begin
                    vectors++;
                    if (cyc - last_done != 6) begin
                        miscompares++;
                        $display("FAIL b2b_spacing #%0d: got %0d clocks required 6", results, cyc - last_done);
                    end
                end
                last_done = cyc;
                results++;
            end
        end
        start = 1'b0;
        vectors++;
        if (results != 256) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results required 256", results);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero_identity();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
